// File: rtl/rng_pkg.sv
// Shared definitions for the RNG consumer: default word width, FSM encodings
// and the substitute for an all-zero seed.
package rng_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // An all-zero seed locks the generator's LFSR, so it is replaced by this value.
    localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

endpackage

// File: rtl/rng_reader_if.sv
// Valid/ready stream from the RNG reader to the MC datapath.
interface rng_reader_if #(
    parameter int WIDTH = rng_pkg::DEFAULT_WIDTH
);

    logic [WIDTH-1:0] num_o;
    logic             num_valid_o;
    logic             num_ready_i;

    modport master (
        output num_o,
        output num_valid_o,
        input  num_ready_i
    );

    modport slave (
        input  num_o,
        input  num_valid_o,
        output num_ready_i
    );

endinterface

// File: rtl/rng_fifo.sv
// Synchronous first-word-fall-through FIFO with flush, occupancy level and
// full/empty flags. Push while full is accepted only alongside a pop.
module rng_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign level   = count;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; its contents are never observed
    // while empty, and rdata is forced to zero in that case.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/rng_reader.sv
// Consumer end of the uniform RNG stream: seeds the generator, discards the
// warm-up run, buffers words and hands them downstream over valid/ready.
module rng_reader
    import rng_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = 8,
    parameter int WARMUP = 64,
    parameter int DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [WIDTH-1:0]        seed_i,
    output logic                    rng_loadseed_o,
    output logic [WIDTH-1:0]        rng_seed_o,
    input  logic [WIDTH-1:0]        rng_number_i,
    rng_reader_if.master            bus,
    output logic [1:0]              state_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic [DROP_W-1:0]       drop_cnt_o
);

    localparam int WW = $clog2(WARMUP + 1);

    state_t            state;
    state_t            state_nx;
    logic [WW-1:0]     warm_cnt;
    logic [DROP_W-1:0] drop_cnt;
    logic [WIDTH-1:0]  seed_q;
    logic [WIDTH-1:0]  fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx       = state;
        push           = 1'b0;
        rng_loadseed_o = 1'b0;
        case (state)
            ST_IDLE:   state_nx = ST_IDLE;
            ST_SEED: begin
                rng_loadseed_o = 1'b1;
                state_nx       = ST_WARMUP;
            end
            ST_WARMUP: if (warm_cnt == WW'(WARMUP - 1)) state_nx = ST_RUN;
            ST_RUN:    push = 1'b1;
            default:   state_nx = ST_IDLE;
        endcase
        // A restart overrides everything, including a word sampled in RUN.
        if (start_i) begin
            state_nx = ST_SEED;
            push     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start_i || state != ST_WARMUP) warm_cnt <= '0;
        else                                      warm_cnt <= warm_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)          seed_q <= '0;
        else if (start_i) seed_q <= (seed_i == '0) ? WIDTH'(ZERO_SEED_SUB) : seed_i;
    end

    // The generator cannot stall: a word that finds no room is lost and counted.
    always_ff @(posedge clk) begin
        if (rst || start_i)
            drop_cnt <= '0;
        else if (push && fifo_full && !pop && drop_cnt != '1)
            drop_cnt <= drop_cnt + 1'b1;
    end

    assign pop = !fifo_empty && bus.num_ready_i;

    rng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (start_i),
        .wdata (rng_number_i),
        .rdata (fifo_rdata),
        .level (level_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.num_o       = fifo_rdata;
    assign bus.num_valid_o = !fifo_empty;
    assign rng_seed_o      = seed_q;
    assign state_o         = state;
    assign drop_cnt_o      = drop_cnt;

endmodule
